// File: rtl/ysyx_24080006_axi_mem_slave_pkg.sv
// ysyx_24080006_axi_mem_slave_pkg: AXI channel structs and response codes shared by the LSU and its memory slaves
package ysyx_24080006_axi_mem_slave_pkg;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  typedef struct packed {
    logic [31:0] awaddr;
    logic        awvalid;
    logic [2:0]  awsize;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wlast;
    logic        bready;
  } axi_w_m2s_t;
  typedef struct packed {
    logic       awready;
    logic       wready;
    logic       bvalid;
    logic [1:0] bresp;
  } axi_w_s2m_t;
  typedef struct packed {
    logic [31:0] araddr;
    logic        arvalid;
    logic [2:0]  arsize;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        rready;
  } axi_r_m2s_t;
  typedef struct packed {
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
  } axi_r_s2m_t;
endpackage

// File: rtl/ysyx_24080006_sram_1rw.sv
// ysyx_24080006_sram_1rw: single-port word SRAM with byte write enables and registered read data
module ysyx_24080006_sram_1rw #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          re,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/ysyx_24080006_axi_mem_slave.sv
// ysyx_24080006_axi_mem_slave: single-beat AXI4 responder in front of a byte-strobed word SRAM
module ysyx_24080006_axi_mem_slave
  import ysyx_24080006_axi_mem_slave_pkg::*;
#(
  parameter int          MEM_DEPTH  = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          RD_LATENCY = 1,
  parameter int          WR_LATENCY = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  axi_w_m2s_t w_m2s,
  output axi_w_s2m_t w_s2m,
  input  axi_r_m2s_t r_m2s,
  output axi_r_s2m_t r_s2m
);
  localparam int AW = $clog2(MEM_DEPTH);
  typedef enum logic [2:0] {IDLE, WR_COLLECT, WR_WAIT, WR_RESP, RD_WAIT, RD_RESP} state_t;
  state_t state, state_n;
  logic aw_got, w_got, collect, aw_hs, w_hs, ar_hs, wr_go, b_hs;
  logic [31:0] awaddr_q, wdata_q, rdata_q, sram_q, wr_addr, wr_data, rd_word;
  logic [7:0] awlen_q, wr_len;
  logic [3:0] wstrb_q, wr_strb, sram_we, cnt;
  logic [1:0] bresp_q, rresp_q;
  logic unused_fields;
  function automatic logic in_range(input logic [31:0] a);
    return a >= BASE_ADDR && ((a - BASE_ADDR) >> 2) < 32'(MEM_DEPTH);
  endfunction
  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction
  function automatic logic [1:0] resp_of(input logic [31:0] a, input logic [7:0] len);
    return !in_range(a) ? AXI_RESP_DECERR : |len ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  endfunction
  assign unused_fields = &{1'b0, w_m2s.awsize, w_m2s.awburst, w_m2s.wlast, r_m2s.arsize, r_m2s.arburst};
  // readies are forced low while reset is held so every s2m output reads zero in reset
  assign collect       = state == IDLE || state == WR_COLLECT;
  assign w_s2m.awready = reset && collect && !aw_got;
  assign w_s2m.wready  = reset && collect && !w_got;
  assign r_s2m.arready = reset && state == IDLE && !w_m2s.awvalid && !w_m2s.wvalid;
  assign aw_hs   = w_m2s.awvalid && w_s2m.awready;
  assign w_hs    = w_m2s.wvalid && w_s2m.wready;
  assign ar_hs   = r_m2s.arvalid && r_s2m.arready;
  assign wr_go   = collect && (aw_got || aw_hs) && (w_got || w_hs);
  assign b_hs    = state == WR_RESP && w_m2s.bready;
  assign wr_addr = aw_got ? awaddr_q : w_m2s.awaddr;
  assign wr_len  = aw_got ? awlen_q : w_m2s.awlen;
  assign wr_data = w_got ? wdata_q : w_m2s.wdata;
  assign wr_strb = w_got ? wstrb_q : w_m2s.wstrb;
  assign sram_we = wr_go && in_range(wr_addr) ? wr_strb : 4'h0;
  assign rd_word = rresp_q == AXI_RESP_DECERR ? 32'h0 : sram_q;
  assign w_s2m.bvalid = state == WR_RESP;
  assign w_s2m.bresp  = bresp_q;
  assign r_s2m.rvalid = state == RD_RESP;
  assign r_s2m.rlast  = state == RD_RESP;
  assign r_s2m.rresp  = rresp_q;
  assign r_s2m.rdata  = r_s2m.rvalid ? rd_word : rdata_q;
  ysyx_24080006_sram_1rw #(.DEPTH(MEM_DEPTH), .AW(AW)) u_sram (
    .clock (clock),
    .re    (ar_hs),
    .we    (sram_we),
    .addr  (word_idx(wr_go ? wr_addr : r_m2s.araddr)),
    .wdata (wr_data),
    .rdata (sram_q)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  // a latency of 1 skips the wait state so the response lands in the very next cycle
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, WR_COLLECT:
        state_n = wr_go ? (WR_LATENCY == 1 ? WR_RESP : WR_WAIT)
                : (aw_hs || w_hs) ? WR_COLLECT
                : ar_hs ? (RD_LATENCY == 1 ? RD_RESP : RD_WAIT) : state;
      WR_WAIT: state_n = cnt == 4'd0 ? WR_RESP : WR_WAIT;
      WR_RESP: state_n = w_m2s.bready ? IDLE : WR_RESP;
      RD_WAIT: state_n = cnt == 4'd0 ? RD_RESP : RD_WAIT;
      RD_RESP: state_n = r_m2s.rready ? IDLE : RD_RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      awaddr_q <= '0;
      awlen_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      cnt      <= '0;
      bresp_q  <= '0;
      rresp_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (aw_hs) begin
        aw_got   <= 1'b1;
        awaddr_q <= w_m2s.awaddr;
        awlen_q  <= w_m2s.awlen;
      end
      if (w_hs) begin
        w_got   <= 1'b1;
        wdata_q <= w_m2s.wdata;
        wstrb_q <= w_m2s.wstrb;
      end
      if (b_hs) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if ((state == WR_WAIT || state == RD_WAIT) && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (wr_go) begin
        cnt     <= 4'(WR_LATENCY - 2);
        bresp_q <= resp_of(wr_addr, wr_len);
      end
      if (ar_hs) begin
        cnt     <= 4'(RD_LATENCY - 2);
        rresp_q <= resp_of(r_m2s.araddr, r_m2s.arlen);
      end
      if (r_s2m.rvalid) rdata_q <= rd_word;
    end
  end
endmodule
